// File: rtl/lif_array_integrator.sv
// rtl/lif_array_integrator.sv - time-multiplexed leaky integrate-and-fire neuron array, 4-stage pipeline
module lif_array_integrator #(
    parameter int WIDTH     = 25,
    parameter int DECAY_W   = 14,
    parameter int FRAC      = 12,
    parameter int N_NEURONS = 16,
    parameter int REF_W     = 4,
    localparam int IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IDX_W-1:0]          in_idx,
    input  logic signed [WIDTH-1:0]   stimulus,
    input  logic signed [DECAY_W-1:0] decay,
    input  logic signed [WIDTH-1:0]   threshold,
    input  logic [REF_W-1:0]          refractory,
    input  logic                      detection,
    input  logic                      reset_mode,
    input  logic                      clear,
    output logic                      out_valid,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      spike,
    output logic signed [WIDTH-1:0]   v_out
);

    localparam int PW = WIDTH + DECAY_W - 1;
    localparam logic [WIDTH-1:0] V_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] V_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0] ROUND_BIAS = PW'((1 << FRAC) - 1);

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] x);
        if (x[WIDTH] != x[WIDTH-1]) return x[WIDTH] ? V_MIN : V_MAX;
        return x[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] mem_v   [N_NEURONS];
    logic [REF_W-1:0]        mem_ref [N_NEURONS];

    logic                      s1_valid, s2_valid, s3_valid, s4_valid;
    logic [IDX_W-1:0]          s1_idx, s2_idx, s3_idx, s4_idx;
    logic signed [WIDTH-1:0]   s1_stim, s2_stim, s3_stim;
    logic signed [DECAY_W-1:0] s1_decay, s2_decay;
    logic signed [WIDTH-1:0]   s1_thr, s2_thr, s3_thr, s4_thr;
    logic [REF_W-1:0]          s1_refr, s2_refr, s3_refr, s4_refr;
    logic [REF_W-1:0]          s2_ref, s3_ref, s4_ref;
    logic                      s1_det, s2_det, s3_det, s4_det;
    logic                      s1_mode, s2_mode, s3_mode, s4_mode;
    logic signed [WIDTH-1:0]   s2_v, s4_sum;
    logic [PW-1:0]             s3_p;

    logic                      accept;
    logic [PW-1:0]             prod;
    logic [PW-1:0]             p_biased;
    logic [WIDTH-1:0]          d;
    logic [WIDTH:0]            sum_wide;
    logic [WIDTH:0]            sub_wide;
    logic                      fire;
    logic signed [WIDTH-1:0]   v_new;
    logic [REF_W-1:0]          ref_new;
    logic                      unused_p;

    // Stall while the requested neuron is anywhere in flight; no forwarding path exists.
    always_comb begin
        in_ready = !clear;
        if (s1_valid && s1_idx == in_idx) in_ready = 1'b0;
        if (s2_valid && s2_idx == in_idx) in_ready = 1'b0;
        if (s3_valid && s3_idx == in_idx) in_ready = 1'b0;
        if (s4_valid && s4_idx == in_idx) in_ready = 1'b0;
    end

    assign accept = in_valid && in_ready;

    assign prod = {{(PW-WIDTH){s2_v[WIDTH-1]}}, s2_v}
                * {{(PW-DECAY_W){s2_decay[DECAY_W-1]}}, s2_decay};

    // Biasing negative products before the arithmetic shift gives truncation toward zero.
    assign p_biased = s3_p + (s3_p[PW-1] ? ROUND_BIAS : '0);
    assign d        = p_biased[FRAC +: WIDTH];
    assign sum_wide = {d[WIDTH-1], d} + {s3_stim[WIDTH-1], s3_stim};
    assign unused_p = ^p_biased;

    always_comb begin
        fire     = s4_det && (s4_ref == '0) && (s4_sum >= s4_thr);
        sub_wide = {s4_sum[WIDTH-1], s4_sum} - {s4_thr[WIDTH-1], s4_thr};
        v_new    = s4_sum;
        ref_new  = (s4_ref != '0) ? s4_ref - REF_W'(1) : '0;
        if (fire) begin
            v_new   = s4_mode ? sat(sub_wide) : '0;
            ref_new = s4_refr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_v[i]   <= '0;
                mem_ref[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_v[i]   <= '0;
                mem_ref[i] <= '0;
            end
        end else if (s4_valid) begin
            mem_v[s4_idx]   <= v_new;
            mem_ref[s4_idx] <= ref_new;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {s1_valid, s2_valid, s3_valid, s4_valid} <= '0;
            {s1_idx, s2_idx, s3_idx, s4_idx}         <= '0;
            {s1_stim, s2_stim, s3_stim}              <= '0;
            {s1_decay, s2_decay}                     <= '0;
            {s1_thr, s2_thr, s3_thr, s4_thr}         <= '0;
            {s1_refr, s2_refr, s3_refr, s4_refr}     <= '0;
            {s2_ref, s3_ref, s4_ref}                 <= '0;
            {s1_det, s2_det, s3_det, s4_det}         <= '0;
            {s1_mode, s2_mode, s3_mode, s4_mode}     <= '0;
            s2_v      <= '0;
            s3_p      <= '0;
            s4_sum    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            spike     <= 1'b0;
            v_out     <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid && !clear;
            s3_valid <= s2_valid && !clear;
            s4_valid <= s3_valid && !clear;
            out_valid <= s4_valid && !clear;
            if (accept) begin
                s1_idx   <= in_idx;
                s1_stim  <= stimulus;
                s1_decay <= decay;
                s1_thr   <= threshold;
                s1_refr  <= refractory;
                s1_det   <= detection;
                s1_mode  <= reset_mode;
            end
            s2_idx   <= s1_idx;
            s2_v     <= mem_v[s1_idx];
            s2_ref   <= mem_ref[s1_idx];
            s2_stim  <= (mem_ref[s1_idx] != '0) ? '0 : s1_stim;
            s2_decay <= s1_decay;
            s2_thr   <= s1_thr;
            s2_refr  <= s1_refr;
            s2_det   <= s1_det;
            s2_mode  <= s1_mode;
            s3_idx   <= s2_idx;
            s3_p     <= prod;
            s3_stim  <= s2_stim;
            s3_ref   <= s2_ref;
            s3_thr   <= s2_thr;
            s3_refr  <= s2_refr;
            s3_det   <= s2_det;
            s3_mode  <= s2_mode;
            s4_idx   <= s3_idx;
            s4_sum   <= sat(sum_wide);
            s4_ref   <= s3_ref;
            s4_thr   <= s3_thr;
            s4_refr  <= s3_refr;
            s4_det   <= s3_det;
            s4_mode  <= s3_mode;
            if (s4_valid && !clear) begin
                out_idx <= s4_idx;
                spike   <= fire;
                v_out   <= v_new;
            end
        end
    end

endmodule
